// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM states, fault cause codes and default address map.
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_RANGE    = 2'b10;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] TRAP_PC_DEF    = 32'h0000_00F0;
   localparam int unsigned IMEM_BYTES_DEF = 256;

   // Misalignment is reported ahead of range so a bad low-order address is never masked.
   function automatic logic [1:0] target_cause(input logic [31:0] addr,
                                               input logic [31:0] last_word);
      if (addr[1:0] != 2'b00) begin
         return FC_MISALIGN;
      end else if (addr > last_word) begin
         return FC_RANGE;
      end
      return FC_NONE;
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Combinational next-PC priority mux (jr > jump > branch > sequential)
// plus fetch-target legality check.
module next_pc_sel
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF
) (
   input  logic [31:0] pc_plus4_i,
   input  logic        branch_taken_i,
   input  logic [15:0] branch_imm_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   input  logic        jr_i,
   input  logic [31:0] jr_addr_i,
   output logic [31:0] cand_o,
   output logic        illegal_o,
   output logic [1:0]  cause_o
);

   localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

   logic [31:0] branch_off;

   assign branch_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

   always_comb begin
      cand_o = pc_plus4_i;
      if (jr_i) begin
         cand_o = jr_addr_i;
      end else if (jump_i) begin
         cand_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
      end else if (branch_taken_i) begin
         cand_o = pc_plus4_i + branch_off;
      end
   end

   assign cause_o   = target_cause(cand_o, LAST_WORD);
   assign illegal_o = (cause_o != FC_NONE);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter, fetch FSM and fetch counter feeding the instruction memory.
// Illegal fetch targets are redirected to TRAP_PC with a one-cycle fault pulse.
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] TRAP_PC    = TRAP_PC_DEF,
   parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fetch_count
);

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic        valid_q;
   logic        fault_q;
   logic [1:0]  cause_q;

   logic [31:0] cand;
   logic        cand_illegal;
   logic [1:0]  cand_cause;

   assign pc_plus4 = pc_q + 32'd4;
   assign count_d  = count_q + 32'd1;

   next_pc_sel #(
      .IMEM_BYTES (IMEM_BYTES)
   ) u_next_pc_sel (
      .pc_plus4_i     (pc_plus4),
      .branch_taken_i (branch_taken),
      .branch_imm_i   (branch_imm),
      .jump_i         (jump),
      .jump_index_i   (jump_index),
      .jr_i           (jr),
      .jr_addr_i      (jr_addr),
      .cand_o         (cand),
      .illegal_o      (cand_illegal),
      .cause_o        (cand_cause)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         count_q <= 32'd0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
               fault_q <= 1'b0;
            end
            RUN: begin
               // A stalled cycle drops any redirect; upstream re-presents it.
               if (!stall) begin
                  count_q <= count_d;
                  if (cand_illegal) begin
                     state_q <= TRAP;
                     pc_q    <= TRAP_PC;
                     valid_q <= 1'b0;
                     fault_q <= 1'b1;
                     cause_q <= cand_cause;
                  end else begin
                     pc_q <= cand;
                  end
               end
            end
            TRAP: begin
               // The trap cycle itself presents TRAP_PC; fetching resumes at the next word.
               state_q <= RUN;
               pc_q    <= pc_plus4;
               valid_q <= 1'b1;
               fault_q <= 1'b0;
            end
            default: begin
               state_q <= BOOT;
               pc_q    <= RESET_PC;
               valid_q <= 1'b0;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = valid_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, async-reset sequences,
// then randomized traffic against an address-arithmetic reference model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] TB_TRAP = 32'h0000_00F0;
   localparam logic [31:0] TB_LAST = 32'h0000_00FC;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_index   (jump_index),
      .jr           (jr),
      .jr_addr      (jr_addr),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .fetch_valid  (fetch_valid),
      .fault        (fault),
      .fault_cause  (fault_cause),
      .fetch_count  (fetch_count)
   );

   typedef struct {
      logic        st;
      logic        br;
      logic [15:0] imm;
      logic        jm;
      logic [25:0] idx;
      logic        j;
      logic [31:0] ja;
      logic [31:0] e_pc;
      logic        e_valid;
      logic        e_fault;
      logic [1:0]  e_cause;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];

   function automatic vec_t mk(logic st, logic br, logic [15:0] imm, logic jm,
                               logic [25:0] idx, logic j, logic [31:0] ja,
                               logic [31:0] p, logic v, logic f, logic [1:0] c,
                               logic [31:0] n);
      vec_t r;
      r.st = st; r.br = br; r.imm = imm; r.jm = jm; r.idx = idx; r.j = j; r.ja = ja;
      r.e_pc = p; r.e_valid = v; r.e_fault = f; r.e_cause = c; r.e_cnt = n;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [31:0] p, logic v, logic f,
                          logic [1:0] c, logic [31:0] n);
      chk({tag, ".pc"}, pc, p);
      chk({tag, ".pc_plus4"}, pc_plus4, p + 32'd4);
      chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(v));
      chk({tag, ".fault"}, 32'(fault), 32'(f));
      chk({tag, ".fault_cause"}, 32'(fault_cause), 32'(c));
      chk({tag, ".fetch_count"}, fetch_count, n);
   endtask

   task automatic clear_inputs();
      stall = 0; branch_taken = 0; branch_imm = '0; jump = 0;
      jump_index = '0; jr = 0; jr_addr = '0;
   endtask

   // Reference model: tracks the fetch address and the "just booted" / "in trap" phases.
   logic [31:0] m_pc, m_count;
   logic [1:0]  m_cause;
   logic        m_boot, m_trap, m_fault;

   task automatic model_reset();
      m_pc = 32'd0; m_count = 32'd0; m_cause = 2'd0;
      m_boot = 1; m_trap = 0; m_fault = 0;
   endtask

   task automatic model_edge();
      logic [31:0] t;
      logic [31:0] p4;
      m_fault = 0;
      if (m_boot) begin
         m_boot = 0;
      end else if (m_trap) begin
         m_trap = 0;
         m_pc = TB_TRAP + 32'd4;
      end else if (!stall) begin
         m_count = m_count + 32'd1;
         p4 = m_pc + 32'd4;
         if (jr)                t = jr_addr;
         else if (jump)         t = (p4 & 32'hF000_0000) + 32'(jump_index) * 32'd4;
         else if (branch_taken) t = p4 + 32'(int'($signed(branch_imm)) * 4);
         else                   t = p4;
         if (t % 4 != 0) begin
            m_trap = 1; m_fault = 1; m_cause = 2'd1; m_pc = TB_TRAP;
         end else if (t > TB_LAST) begin
            m_trap = 1; m_fault = 1; m_cause = 2'd2; m_pc = TB_TRAP;
         end else begin
            m_pc = t;
         end
      end
   endtask

   initial begin
      vecs[0]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h00,1,0,2'd0,32'd0);
      vecs[1]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h04,1,0,2'd0,32'd1);
      vecs[2]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h08,1,0,2'd0,32'd2);
      vecs[3]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h0C,1,0,2'd0,32'd3);
      vecs[4]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h10,1,0,2'd0,32'd4);
      vecs[5]  = mk(0,1,16'hFFFE,0,26'h0,0,32'h00, 32'h0C,1,0,2'd0,32'd5);
      vecs[6]  = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'h10,1,0,2'd0,32'd6);
      vecs[7]  = mk(0,1,16'h0003,0,26'h0,0,32'h00, 32'h20,1,0,2'd0,32'd7);
      vecs[8]  = mk(0,1,16'h0001,1,26'h5,1,32'h40, 32'h40,1,0,2'd0,32'd8);
      vecs[9]  = mk(0,0,16'h0000,0,26'h0,1,32'h20, 32'h20,1,0,2'd0,32'd9);
      vecs[10] = mk(1,0,16'h0000,0,26'h0,1,32'h40, 32'h20,1,0,2'd0,32'd9);
      vecs[11] = mk(1,0,16'h0000,0,26'h0,1,32'h40, 32'h20,1,0,2'd0,32'd9);
      vecs[12] = mk(0,0,16'h0000,0,26'h0,1,32'h40, 32'h40,1,0,2'd0,32'd10);
      vecs[13] = mk(0,0,16'h0000,0,26'h0,1,32'h42, 32'hF0,0,1,2'd1,32'd11);
      vecs[14] = mk(1,0,16'h0000,0,26'h0,1,32'h80, 32'hF4,1,0,2'd1,32'd11);
      vecs[15] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF8,1,0,2'd1,32'd12);
      vecs[16] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hFC,1,0,2'd1,32'd13);
      vecs[17] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF0,0,1,2'd2,32'd14);
      vecs[18] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF4,1,0,2'd2,32'd14);
      vecs[19] = mk(0,0,16'h0000,1,26'h10,0,32'h00, 32'h40,1,0,2'd2,32'd15);
      vecs[20] = mk(0,0,16'h0000,0,26'h0,1,32'h43, 32'hF0,0,1,2'd1,32'd16);
      vecs[21] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF4,1,0,2'd1,32'd16);
      vecs[22] = mk(0,0,16'h0000,1,26'h40,0,32'h00, 32'hF0,0,1,2'd2,32'd17);
      vecs[23] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF4,1,0,2'd2,32'd17);
      vecs[24] = mk(0,0,16'h0000,0,26'h0,1,32'h101, 32'hF0,0,1,2'd1,32'd18);
      vecs[25] = mk(0,0,16'h0000,0,26'h0,0,32'h00, 32'hF4,1,0,2'd1,32'd18);
      vecs[26] = mk(0,0,16'h0000,0,26'h0,1,32'h30, 32'h30,1,0,2'd1,32'd19);

      // Reset held for three cycles, then released between edges into BOOT.
      clear_inputs();
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 32'h0, 0, 0, 2'd0, 32'd0);
      reset = 1;
      @(negedge clk);
      chk_all("boot", 32'h0, 0, 0, 2'd0, 32'd0);
      $display("txn reset_release pc=%h valid=%0b", pc, fetch_valid);

      for (int i = 0; i < NVEC; i++) begin
         stall = vecs[i].st; branch_taken = vecs[i].br; branch_imm = vecs[i].imm;
         jump = vecs[i].jm; jump_index = vecs[i].idx; jr = vecs[i].j; jr_addr = vecs[i].ja;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_fault,
                 vecs[i].e_cause, vecs[i].e_cnt);
         $display("txn vec%0d pc=%h valid=%0b fault=%0b cause=%0d count=%0d",
                  i, pc, fetch_valid, fault, fault_cause, fetch_count);
      end

      // Async reset between edges while running at pc=0x30.
      clear_inputs();
      #3 reset = 0;
      #1;
      chk_all("async_run", 32'h0, 0, 0, 2'd0, 32'd0);
      $display("txn async_reset_run pc=%h count=%0d", pc, fetch_count);
      @(posedge clk);
      #1 reset = 1;
      // Stall and redirect are ignored during BOOT.
      stall = 1; jr = 1; jr_addr = 32'h40;
      @(posedge clk);
      #1;
      chk_all("boot_stall", 32'h0, 1, 0, 2'd0, 32'd0);
      $display("txn boot_stall pc=%h valid=%0b", pc, fetch_valid);
      stall = 0; jr_addr = 32'h42;
      @(posedge clk);
      #1;
      chk_all("trap_entry", TB_TRAP, 0, 1, 2'd1, 32'd1);
      $display("txn trap_entry pc=%h cause=%0d", pc, fault_cause);
      #2 reset = 0;
      #1;
      chk_all("async_trap", 32'h0, 0, 0, 2'd0, 32'd0);
      $display("txn async_reset_trap pc=%h cause=%0d", pc, fault_cause);
      clear_inputs();

      // Randomized traffic against the reference model.
      model_reset();
      @(posedge clk);
      #1 reset = 1;
      for (int i = 0; i < 400; i++) begin
         stall        = ($urandom_range(0, 4) == 0);
         jr           = ($urandom_range(0, 7) == 0);
         jump         = ($urandom_range(0, 7) == 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         jr_addr      = 32'($urandom_range(0, 32'h108));
         if ($urandom_range(0, 3) != 0) jr_addr[1:0] = 2'b00;
         jump_index   = 26'($urandom_range(0, 32'h45));
         branch_imm   = 16'(int'($urandom_range(0, 80)) - 40);
         if (i == 200) begin
            #3 reset = 0;
            #1;
            model_reset();
            chk_all("rand_async", m_pc, 1'b0, m_fault, m_cause, m_count);
            @(posedge clk);
            #1 reset = 1;
         end
         @(posedge clk);
         model_edge();
         #1;
         chk_all($sformatf("rand%0d", i), m_pc, !(m_boot || m_trap), m_fault, m_cause, m_count);
         $display("txn rand%0d pc=%h valid=%0b fault=%0b cause=%0d count=%0d",
                  i, pc, fetch_valid, fault, fault_cause, fetch_count);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
